// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode stream decoder: parses make/break/extended prefixes and
// tracks shift, the held key, its ASCII value and a BCD press count.
module ps2_scancode_decoder #(
  parameter logic [7:0] BREAK_CODE   = 8'hF0,
  parameter logic [7:0] EXT_CODE     = 8'hE0,
  parameter bit         HOLD_DISPLAY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ready,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic [7:0] key_count,
  output logic       key_down,
  output logic       key_ext,
  output logic       shift,
  output logic       event_valid
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [7:0] LSHIFT_CODE = 8'h12;
  localparam logic [7:0] RSHIFT_CODE = 8'h59;

  state_t     state, state_next;
  logic       is_make, is_break, code_ext;
  logic       lshift, rshift;
  logic       is_shift_code, same_key;
  logic [7:0] make_ascii;

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      default: a = '0;
    endcase
    if (upper && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    return a;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] c);
    logic [7:0] r;
    if (c[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (c[7:4] == 4'd9) ? 4'd0 : c[7:4] + 4'd1;
    end else begin
      r[3:0] = c[3:0] + 4'd1;
      r[7:4] = c[7:4];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    is_make    = 1'b0;
    is_break   = 1'b0;
    code_ext   = 1'b0;
    if (ready) begin
      case (state)
        IDLE: begin
          if (data == EXT_CODE)        state_next = EXT;
          else if (data == BREAK_CODE) state_next = BRK;
          else                         is_make = 1'b1;
        end
        EXT: begin
          if (data == BREAK_CODE) state_next = EXT_BRK;
          else if (data != EXT_CODE) begin
            is_make    = 1'b1;
            code_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          if (data != BREAK_CODE && data != EXT_CODE) begin
            is_break   = 1'b1;
            state_next = IDLE;
          end
        end
        EXT_BRK: begin
          if (data != BREAK_CODE && data != EXT_CODE) begin
            is_break   = 1'b1;
            code_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    is_shift_code = !code_ext && (data == LSHIFT_CODE || data == RSHIFT_CODE);
    same_key      = key_down && key_code == data && key_ext == code_ext;
    make_ascii    = code_ext ? '0 : ascii_of(data, shift);
  end

  // Shift makes/breaks never touch the displayed key; a make of the held key is a typematic repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code    <= '0;
      key_ascii   <= '0;
      key_count   <= '0;
      key_down    <= 1'b0;
      key_ext     <= 1'b0;
      shift       <= 1'b0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      event_valid <= 1'b0;
    end else begin
      event_valid <= 1'b0;
      if (is_make) begin
        if (is_shift_code) begin
          if (data == LSHIFT_CODE) lshift <= 1'b1;
          else                     rshift <= 1'b1;
          shift <= 1'b1;
        end else if (!same_key) begin
          key_code    <= data;
          key_ext     <= code_ext;
          key_ascii   <= make_ascii;
          key_down    <= 1'b1;
          key_count   <= bcd_inc(key_count);
          event_valid <= 1'b1;
        end
      end else if (is_break) begin
        if (is_shift_code) begin
          if (data == LSHIFT_CODE) begin
            lshift <= 1'b0;
            shift  <= rshift;
          end else begin
            rshift <= 1'b0;
            shift  <= lshift;
          end
        end else if (same_key) begin
          key_down    <= 1'b0;
          event_valid <= 1'b1;
          if (!HOLD_DISPLAY) begin
            key_code  <= '0;
            key_ascii <= '0;
            key_ext   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench: a byte-level reference model queues expected events; a monitor
// checks each event_valid pulse, and directed/random phases check full output state.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = '0;
  logic       ready = 1'b0;
  logic [7:0] key_code, key_ascii, key_count;
  logic       key_down, key_ext, shift, event_valid;

  int errors = 0;
  int checks = 0;
  int ev_seen = 0;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic [7:0] count;
    logic       down;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];

  // reference model state
  logic [7:0] m_code, m_ascii;
  logic       m_ext, m_down, m_lsh, m_rsh;
  int         m_cnt;
  logic       p_ext, p_brk;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] pool [8] = '{8'h1C, 8'h32, 8'h21, 8'h29, 8'h16, 8'h75, 8'h1A, 8'h45};

  ps2_scancode_decoder #(
    .BREAK_CODE  (8'hF0),
    .EXT_CODE    (8'hE0),
    .HOLD_DISPLAY(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .ready      (ready),
    .key_code   (key_code),
    .key_ascii  (key_ascii),
    .key_count  (key_count),
    .key_down   (key_down),
    .key_ext    (key_ext),
    .shift      (shift),
    .event_valid(event_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input logic upper);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) return (upper ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) return 8'h30 + 8'(i);
    if (code == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_code = '0; m_ascii = '0; m_ext = 0; m_down = 0; m_lsh = 0; m_rsh = 0;
    m_cnt = 0; p_ext = 0; p_brk = 0;
    exp_q.delete();
  endtask

  task automatic model_key(input logic [7:0] code, input logic ext, input logic brk);
    logic is_shift;
    logic same;
    is_shift = !ext && (code == 8'h12 || code == 8'h59);
    same     = m_down && m_code == code && m_ext == ext;
    if (!brk) begin
      if (is_shift) begin
        if (code == 8'h12) m_lsh = 1; else m_rsh = 1;
      end else if (!same) begin
        m_ascii = ext ? 8'h00 : ref_ascii(code, m_lsh | m_rsh);
        m_code  = code;
        m_ext   = ext;
        m_down  = 1;
        m_cnt   = (m_cnt + 1) % 100;
        exp_q.push_back('{m_code, m_ascii, to_bcd(m_cnt), 1'b1, m_ext});
      end
    end else begin
      if (is_shift) begin
        if (code == 8'h12) m_lsh = 0; else m_rsh = 0;
      end else if (same) begin
        m_down = 0;
        exp_q.push_back('{m_code, m_ascii, to_bcd(m_cnt), 1'b0, m_ext});
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      if (!p_brk) p_ext = 1;
    end else if (b == 8'hF0) begin
      p_brk = 1;
    end else begin
      model_key(b, p_ext, p_brk);
      p_ext = 0;
      p_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap = 0);
    @(negedge clk);
    data  = b;
    ready = 1'b1;
    model_byte(b);
    @(negedge clk);
    ready = 1'b0;
    data  = $urandom_range(0, 255);
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".key_code"},  key_code,  m_code);
    chk({tag, ".key_ascii"}, key_ascii, m_ascii);
    chk({tag, ".key_count"}, key_count, to_bcd(m_cnt));
    chk({tag, ".key_down"},  key_down,  m_down);
    chk({tag, ".key_ext"},   key_ext,   m_ext);
    chk({tag, ".shift"},     shift,     m_lsh | m_rsh);
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, ".pending_events"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // monitor: every event pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && event_valid) begin
      ev_t e, act;
      ev_seen++;
      act = '{key_code, key_ascii, key_count, key_down, key_ext};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got code=%0h down=%0b count=%0h, expected no event at %0t",
                 key_code, key_down, key_count, $time);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL event: got code=%0h ascii=%0h count=%0h down=%0b ext=%0b expected code=%0h ascii=%0h count=%0h down=%0b ext=%0b",
                   act.code, act.ascii, act.count, act.down, act.ext,
                   e.code, e.ascii, e.count, e.down, e.ext);
        end
      end
    end
  end

  initial begin
    int ev0;
    logic [7:0] b;
    model_reset();

    // reset values
    do_reset();
    check_state("reset");
    chk("reset.event_valid", event_valid, 0);

    // test 1: press/release A
    send(8'h1C);
    chk("t1.ascii_a", key_ascii, 8'h61);
    chk("t1.count", key_count, 8'h01);
    check_state("t1.make");
    send(8'hF0); send(8'h1C);
    chk("t1.release_down", key_down, 0);
    chk("t1.hold_code", key_code, 8'h1C);
    drain("t1");

    // test 2: typematic repeats
    do_reset();
    ev0 = ev_seen;
    repeat (5) send(8'h1C, 1);
    drain("t2");
    chk("t2.count", key_count, 8'h01);
    chk("t2.events", ev_seen - ev0, 1);

    // test 3: shifted A
    do_reset();
    send(8'h12);
    chk("t3.shift_on", shift, 1);
    send(8'h1C);
    chk("t3.ascii_upper", key_ascii, 8'h41);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t3.shift_off", shift, 0);
    chk("t3.count", key_count, 8'h01);
    chk("t3.ascii_kept", key_ascii, 8'h41);
    drain("t3");

    // test 4: BCD count and wrap
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      send(8'h32); send(8'hF0); send(8'h32);
      if (i == 9)   chk("t4.count9", key_count, 8'h09);
      if (i == 10)  chk("t4.count10", key_count, 8'h10);
      if (i == 99)  chk("t4.count99", key_count, 8'h99);
      if (i == 100) chk("t4.count_wrap", key_count, 8'h00);
    end
    drain("t4");

    // test 5: extended key
    do_reset();
    send(8'hE0); send(8'h75);
    chk("t5.ext", key_ext, 1);
    chk("t5.ascii", key_ascii, 8'h00);
    send(8'hF0); send(8'h75);
    chk("t5.nonext_break_ignored", key_down, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t5.ext_break", key_down, 0);
    check_state("t5");
    drain("t5");

    // test 6: reset clears pending prefix, even with a coincident byte
    do_reset();
    send(8'hF0);
    @(negedge clk);
    rst = 1'b1; ready = 1'b1; data = 8'h1C;
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    model_reset();
    check_state("t6.after_rst");
    send(8'h1C);
    chk("t6.make_down", key_down, 1);
    chk("t6.count", key_count, 8'h01);
    drain("t6");

    // randomized byte stream
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1, 2:    b = 8'hF0;
        3:       b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        8:       b = 8'($urandom_range(0, 255));
        default: b = pool[$urandom_range(0, 7)];
      endcase
      send(b, $urandom_range(0, 2));
      if (n % 100 == 99) check_state("rand");
    end
    drain("rand");
    check_state("rand.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
